// File: rtl/depthwise_conv3x3_nch.sv
// Per-channel 3x3 stride-1 zero-padded float32 convolution with a writable tap file and frame control.
// Output follows the channel pipeline directly; Ready_In drops outside READY/RUN and while the frame drains.

// Single-channel 3x3 conv over a raster stream, 3 cycles from window step to data_out.
// No backpressure: after the last input pixel it self-steps W+1 zero pixels to flush the bottom row.
module Convolution2D_3x3_stride_1x1_padding_1x1 #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WIDHT-1:0]   data_in,
  input  logic [9*DATA_WIDHT-1:0] taps,
  output logic [DATA_WIDHT-1:0]   data_out,
  output logic                    valid_out
);
  localparam int W    = IMG_WIDHT;
  localparam int H    = IMG_HEIGHT;
  localparam int N    = W * H;
  localparam int LAST = N + W;
  localparam int SL   = 2 * W + 3;
  localparam int SW   = $clog2(LAST + 1);
  localparam int CB   = $clog2(W + 1);
  localparam int RB   = $clog2(H + 1);

  // Truncating float32 multiply; denormals flush to zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (e[9] || e == 10'd0) return {s, 31'd0};
    if (e >= 10'd255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], m[45:23]};
  endfunction

  // Truncating float32 add; denormals flush to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [24:0] mx, my, sm;
    logic [8:0]  e;
    logic [7:0]  d;
    logic [4:0]  lz;
    if (b[30:23] == 8'd0) return a;
    if (a[30:23] == 8'd0) return b;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {2'b01, x[22:0]};
    my = (d > 8'd24) ? 25'd0 : ({2'b01, y[22:0]} >> d);
    e  = {1'b0, x[30:23]};
    if (x[31] == y[31]) begin
      sm = mx + my;
      if (sm[24]) begin
        sm = sm >> 1;
        e  = e + 9'd1;
      end
      if (e >= 9'd255) return {x[31], 8'hFF, 23'd0};
    end else begin
      sm = mx - my;
      if (sm == 25'd0) return 32'd0;
      lz = 5'd0;
      for (int i = 0; i < 24; i++) if (sm[i]) lz = 5'(23 - i);
      sm = sm << lz;
      if (e <= {4'd0, lz}) return 32'd0;
      e = e - {4'd0, lz};
    end
    return {x[31], e[7:0], sm[22:0]};
  endfunction

  logic [SW-1:0]         cnt;
  logic [DATA_WIDHT-1:0] sr [SL];
  logic [DATA_WIDHT-1:0] prod_n [9];
  logic [DATA_WIDHT-1:0] prod [9];
  logic [DATA_WIDHT-1:0] sum;
  logic [CB-1:0]         col;
  logic [RB-1:0]         row;
  logic                  drain, step, win_vld, prod_vld;
  logic                  top, bot, lft, rgt;

  assign drain = cnt >= SW'(N);
  assign step  = valid_in | drain;
  assign top   = row == '0;
  assign bot   = row == RB'(H - 1);
  assign lft   = col == '0;
  assign rgt   = col == CB'(W - 1);

  // sr[0] is the newest pixel; when win_vld is high, sr[W+1] is the centre pixel of the output.
  always_comb begin
    prod_n = '{default: '0};
    for (int k = 0; k < 9; k++) begin
      if (!((k < 3 && top) || (k > 5 && bot) || (k % 3 == 0 && lft) || (k % 3 == 2 && rgt)))
        prod_n[k] = fp_mul(sr[(2 - k / 3) * W + 2 - k % 3], taps[k*DATA_WIDHT +: DATA_WIDHT]);
    end
  end

  assign sum = fp_add(fp_add(fp_add(fp_add(prod[0], prod[1]), fp_add(prod[2], prod[3])),
                             fp_add(fp_add(prod[4], prod[5]), fp_add(prod[6], prod[7]))), prod[8]);

  always_ff @(posedge clk) begin
    if (step) begin
      sr[0] <= drain ? '0 : data_in;
      for (int i = 1; i < SL; i++) sr[i] <= sr[i-1];
    end
    if (win_vld) prod <= prod_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      win_vld   <= 1'b0;
      prod_vld  <= 1'b0;
      col       <= '0;
      row       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      win_vld  <= step && (cnt >= SW'(W + 1));
      prod_vld <= win_vld;
      if (step) cnt <= (cnt == SW'(LAST)) ? '0 : cnt + 1'b1;
      if (win_vld) begin
        if (rgt) begin
          col <= '0;
          row <= bot ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      valid_out <= prod_vld;
      if (prod_vld) data_out <= sum;
    end
  end
endmodule

// Depthwise wrapper: tap register file, frame FSM and per-channel conv instances.
// Adds no latency beyond the channel pipeline; Ready_In only in READY or RUN below a full frame.
module depthwise_conv3x3_nch #(
  parameter int DATA_WIDHT  = 32,
  parameter int IMG_WIDHT   = 44,
  parameter int IMG_HEIGHT  = 44,
  parameter int NUM_CHANNEL = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              Kernel_Wr_En,
  input  logic [$clog2(NUM_CHANNEL*9)-1:0]  Kernel_Wr_Addr,
  input  logic [DATA_WIDHT-1:0]             Kernel_Wr_Data,
  input  logic [DATA_WIDHT*NUM_CHANNEL-1:0] Data_In,
  input  logic                              Valid_In,
  output logic                              Ready_In,
  output logic [DATA_WIDHT*NUM_CHANNEL-1:0] Data_Out,
  output logic                              Valid_Out,
  output logic                              Frame_Done,
  output logic                              Kernel_Ready,
  output logic                              Err
);
  localparam int NT = NUM_CHANNEL * 9;
  localparam int AW = $clog2(NT);
  localparam int N  = IMG_WIDHT * IMG_HEIGHT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, READY, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [DATA_WIDHT-1:0]  taps [NT];
  logic [NT-1:0]          written, written_nxt;
  logic [CW-1:0]          in_cnt, out_cnt;
  logic [NUM_CHANNEL-1:0] ch_vld;
  logic                   addr_ok, kern_open, kern_we, accept;

  assign addr_ok      = {1'b0, Kernel_Wr_Addr} < (AW + 1)'(NT);
  assign kern_open    = (state == IDLE) || (state == READY);
  assign kern_we      = Kernel_Wr_En && addr_ok && kern_open;
  assign Kernel_Ready = &written;
  assign Ready_In     = (state == READY) || (state == RUN && in_cnt < CW'(N));
  assign accept       = Valid_In && Ready_In;
  assign Valid_Out    = &ch_vld;

  always_comb begin
    written_nxt = written;
    if (kern_we) written_nxt[Kernel_Wr_Addr] = 1'b1;
  end

  // Leaving IDLE on the completing write makes Ready_In rise together with Kernel_Ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (&written_nxt) state_nxt = READY;
      READY:   if (accept) state_nxt = RUN;
      RUN:     if (in_cnt == CW'(N)) state_nxt = DRAIN;
      DRAIN:   if (Frame_Done) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      written    <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      Frame_Done <= 1'b0;
      Err        <= 1'b0;
    end else begin
      state   <= state_nxt;
      written <= written_nxt;
      if (state == DRAIN && Frame_Done) in_cnt <= '0;
      else if (accept) in_cnt <= in_cnt + 1'b1;
      if (Valid_Out) out_cnt <= (out_cnt == CW'(N - 1)) ? '0 : out_cnt + 1'b1;
      Frame_Done <= Valid_Out && (out_cnt == CW'(N - 1));
      if ((Kernel_Wr_En && !(addr_ok && kern_open)) || (|ch_vld && !Valid_Out)) Err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (kern_we) taps[Kernel_Wr_Addr] <= Kernel_Wr_Data;
  end

  for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
    logic [9*DATA_WIDHT-1:0] ch_taps;
    for (genvar k = 0; k < 9; k++) begin : g_tap
      assign ch_taps[k*DATA_WIDHT +: DATA_WIDHT] = taps[c*9 + k];
    end
    Convolution2D_3x3_stride_1x1_padding_1x1 #(
      .DATA_WIDHT (DATA_WIDHT),
      .IMG_WIDHT  (IMG_WIDHT),
      .IMG_HEIGHT (IMG_HEIGHT)
    ) u_conv (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (accept),
      .data_in   (Data_In[c*DATA_WIDHT +: DATA_WIDHT]),
      .taps      (ch_taps),
      .data_out  (Data_Out[c*DATA_WIDHT +: DATA_WIDHT]),
      .valid_out (ch_vld[c])
    );
  end
endmodule

// File: tb/tb_depthwise_conv3x3_nch.sv
// Scoreboard bench for depthwise_conv3x3_nch with two channels on a 4x4 frame.
module tb_depthwise_conv3x3_nch;
  localparam int DW = 32;
  localparam int NC = 2;
  localparam int AW = $clog2(NC * 9);
  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] TWO = 32'h40000000;

  logic          clk = 1'b0;
  logic          rst, kwe, vin, rdy, vout, fdone, kready, err;
  logic [AW-1:0] kaddr;
  logic [DW-1:0] kdata;
  logic [63:0]   din, dout;

  int total = 0, bad = 0, fd_cnt = 0, acc = 0, acc_at_fd = -1, fd_before = 0;
  logic [63:0] exp_q[$];
  logic [31:0] ftab [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  depthwise_conv3x3_nch #(
    .DATA_WIDHT (DW), .IMG_WIDHT (4), .IMG_HEIGHT (4), .NUM_CHANNEL (NC)
  ) dut (
    .clk (clk), .rst (rst), .Kernel_Wr_En (kwe), .Kernel_Wr_Addr (kaddr),
    .Kernel_Wr_Data (kdata), .Data_In (din), .Valid_In (vin), .Ready_In (rdy),
    .Data_Out (dout), .Valid_Out (vout), .Frame_Done (fdone),
    .Kernel_Ready (kready), .Err (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fdone) fd_cnt++;
    if (vout) begin
      if (exp_q.size() == 0) check("unexpected_valid_out", 64'(vout), 64'd0);
      else check("data_out", dout, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vin = 1'b0; kwe = 1'b0;
    tick(); tick();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic write_tap(input int a, input logic [31:0] d);
    kwe = 1'b1; kaddr = AW'(a); kdata = d;
    tick();
    kwe = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] e);
    bit done;
    done = 1'b0;
    vin = 1'b1; din = d;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (fdone) begin
        acc_at_fd = acc;
        check("ready_low_at_frame_done", 64'(rdy), 64'd0);
      end
      if (rdy) begin
        exp_q.push_back(e);
        acc++;
        done = 1'b1;
      end
      tick();
    end
    if (!done) check("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_frames(input int target);
    for (int n = 0; n < 300 && fd_cnt < target; n++) tick();
    repeat (4) tick();
    check("frame_done_count", 64'(fd_cnt), 64'(target));
  endtask

  // 3x3 all-ones sum with zero padding: count of in-frame neighbours.
  function automatic logic [31:0] ones_exp(input int i);
    int nr, nc;
    nr = (i / 4 == 0 || i / 4 == 3) ? 2 : 3;
    nc = (i % 4 == 0 || i % 4 == 3) ? 2 : 3;
    case (nr * nc)
      4:       return 32'h40800000;
      6:       return 32'h40C00000;
      default: return 32'h41100000;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; kwe = 1'b0; vin = 1'b0; kaddr = '0; kdata = '0; din = '0;
    do_reset();
    check("rst_ready_in", 64'(rdy), 64'd0);
    check("rst_kernel_ready", 64'(kready), 64'd0);
    check("rst_valid_out", 64'(vout), 64'd0);
    check("rst_data_out", dout, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_frame_done", 64'(fdone), 64'd0);

    // Identity kernel, 17 of 18 taps first.
    for (int a = 0; a < 17; a++) write_tap(a, (a % 9 == 4) ? ONE : 32'd0);
    check("kernel_ready_17", 64'(kready), 64'd0);
    check("ready_in_17", 64'(rdy), 64'd0);
    write_tap(17, 32'd0);
    check("kernel_ready_18", 64'(kready), 64'd1);
    check("ready_in_18", 64'(rdy), 64'd1);

    // Identity frame with gaps; a tap write mid-frame must be ignored.
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin kwe = 1'b1; kaddr = AW'(4); kdata = TWO; end
      send({ftab[15-i], ftab[i]}, {ftab[15-i], ftab[i]});
      kwe = 1'b0;
      if (i % 2 == 1) begin vin = 1'b0; tick(); end
    end
    vin = 1'b0;
    wait_frames(1);
    check("err_write_in_run", 64'(err), 64'd1);
    check("queue_empty_identity", 64'(exp_q.size()), 64'd0);

    // Out-of-range tap address, then all-ones kernel over two back-to-back frames.
    do_reset();
    check("err_after_reset", 64'(err), 64'd0);
    write_tap(18, ONE);
    check("err_bad_addr", 64'(err), 64'd1);
    check("kernel_ready_bad_addr", 64'(kready), 64'd0);
    for (int a = 0; a < 18; a++) write_tap(a, ONE);
    acc = 0; acc_at_fd = -1;
    for (int i = 0; i < 32; i++) send({ONE, ONE}, {ones_exp(i % 16), ones_exp(i % 16)});
    vin = 1'b0;
    wait_frames(3);
    check("accepted_before_first_done", 64'(acc_at_fd), 64'd16);
    check("accepted_total", 64'(acc), 64'd32);
    check("queue_empty_ones", 64'(exp_q.size()), 64'd0);

    // Abort a frame after 7 pixels.
    for (int i = 0; i < 7; i++) send({ONE, ONE}, {ones_exp(i), ones_exp(i)});
    vin = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("abort_valid_out", 64'(vout), 64'd0);
    check("abort_data_out", dout, 64'd0);
    check("abort_ready_in", 64'(rdy), 64'd0);
    check("abort_kernel_ready", 64'(kready), 64'd0);
    rst = 1'b0;
    fd_before = fd_cnt;
    repeat (20) tick();
    check("abort_no_frame_done", 64'(fd_cnt), 64'(fd_before));
    check("abort_idle_ready_in", 64'(rdy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
